psum_collector: RTL
===================

# psum_collector

Output-side collector for the systolic MAC array: it captures the skewed per-column partial sums the array emits on its south edge, one column FIFO per column, and presents them re-aligned as full rows. It sits between the array's `out_s`/`valid` outputs and the SFU/psum SRAM write path. Downstream logic reads one aligned `col`-wide row per read handshake.

## Interface
- `bw`, 4, activation/weight width; not used internally, carried for parameter consistency.
- `psum_bw`, 16, partial-sum width per column.
- `col`, 8, number of array columns / column FIFOs.
- `DEPTH`, 64, entries per column FIFO; must be a power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  reset; asynchronous and active-high.
- `in`  in  `psum_bw*col`  south-edge psums; column c is `in[psum_bw*(c+1)-1 : psum_bw*c]`.
- `wr`  in  `col`  per-column write strobe, driven by the array's `valid`.
- `rd`  in  1  read request for one aligned row.
- `out`  out  `psum_bw*col`  head entry of every column FIFO (first-word-fall-through).
- `o_valid`  out  1  every column FIFO is non-empty.
- `o_full`  out  1  at least one column FIFO is full.
- `o_ready`  out  1  no column FIFO is full; equal to `!o_full`.
- `o_ovf`  out  1  sticky error: a write was dropped.

## Operation
- **Column c write.**
  - The write occurs if `wr[c]` is high and column c is not full, or if it is full while a row pop happens in the same cycle.
  - Otherwise the write is dropped and `o_ovf` is set.
- **Row pop.** A pop occurs when `rd && o_valid`. All `col` read pointers advance together.
- **`rd` while `!o_valid`.** Ignored. No pointer moves and there is no error.
- **Pointers.** Each column has `log2(DEPTH)+1`-bit write and read pointers; the extra bit is the wrap bit.
  - Empty: pointers are equal.
  - Full: address bits are equal and wrap bits differ.
  - Pointers wrap modulo `2*DEPTH` with no special casing.
- **Independence.** Columns are written independently. Diagonal skew between columns, up to `col-1` cycles, is absorbed by the FIFOs.
- **Data handling.** No arithmetic is done in the base configuration. Data passes bit-exact, treated as signed two's complement `psum_bw`.
- **`o_ovf`.** Sticky until `reset`. It never clears on its own.

## Timing
- **Reset values.**
  - All pointers are 0.
  - `o_valid`=0, `o_full`=0, `o_ready`=1, `o_ovf`=0.
  - `out` is undefined; the bench must not check it while `o_valid`=0.
  - FIFO storage is not cleared.
- **Write-to-read latency is 1 cycle.** A write at edge N makes the entry visible at the head (and `o_valid` high, if it completes the row) immediately after edge N.
- **Read handshake.** `out` is valid combinationally whenever `o_valid`=1. The pop takes effect at the edge where `rd && o_valid`, and the next row appears after that edge.
- **Simultaneous write and pop on an empty column.** Not possible, because `o_valid`=0 blocks the pop.
- **Simultaneous write and pop on a non-empty column.** Occupancy is unchanged.
- **Reset mid-operation.** Takes effect immediately and asynchronously. Outputs take their reset values and all buffered data is discarded.
- **Flag derivation.** `o_full`, `o_ready` and `o_valid` are derived combinationally from registered pointers, with no combinational path from `rd` or `wr`.

## Configuration
- **`PSUM_COLLECTOR_RELU_EN` defined.**
  - Each column of `out` is ReLU'd on the read side: a negative value (MSB=1) is presented as 0, otherwise it passes through.
  - Stored data is unchanged.
- **Not defined.** `out` is the raw head entry.

## Structure
- **Shared package `psum_pkg`.**
  - Default `PSUM_BW`, `COL` and `PSUM_DEPTH` constants.
  - Pointer-width function `clog2`.
  - The ReLU helper function, shared with the SFU.
- **Sub-module `psum_col_fifo`.**
  - Single-column FWFT FIFO with ports `clk`, `reset`, `wr`, `din`, `pop`, `dout`, `empty`, `full`, `wr_drop`.
  - Instantiated `col` times in a generate loop.
- **Top level.** Holds the `o_valid`/`o_full` reductions, the `o_ovf` register, and the optional ReLU.

## Test plan
- **Reset then idle.** Assert `reset` for 2 cycles -> `o_valid`=0, `o_full`=0, `o_ready`=1, `o_ovf`=0. `rd`=1 for 5 cycles causes no change.
- **Skewed row, `col`=8.**
  - Stimulus: column c gets value 100+c with `wr[c]` asserted at cycle c.
  - `o_valid` stays 0 through the cycle 6 edge and rises after the cycle 7 edge.
  - `out` = {107,…,100}. `rd`=1 for one cycle -> `o_valid` returns to 0.
- **Fill to full.**
  - Write 64 rows with all `wr`=1 and no reads -> `o_full`=1, `o_ready`=0.
  - A 65th write -> dropped, `o_ovf`=1 and stays 1.
  - Reading 64 rows returns 0..63 in order.
- **Full with simultaneous write and read.** Write row 64 and pop in the same cycle -> accepted, `o_ovf` stays 0, occupancy stays 64. Then drain and check order.
- **Wrap-around.** Stream 200 rows with continuous `rd` -> all 200 rows read back in order, never full, no overflow.
- **Configuration and mid-stream reset.**
  - With `PSUM_COLLECTOR_RELU_EN`: write −5 (0xFFFB) and 7 -> `out` shows 0 and 7.
  - Assert `reset` with 10 rows buffered -> `o_valid`=0 immediately, and the next row written reads back first.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared constants and helpers for the psum collector and the SFU.
// Holds the default geometry, the pointer-width function and the ReLU helper.
package psum_pkg;

  localparam int PSUM_BW    = 16;
  localparam int COL        = 8;
  localparam int PSUM_DEPTH = 64;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // Negative two's-complement values clamp to zero.
  function automatic logic [PSUM_BW-1:0] relu(input logic [PSUM_BW-1:0] x);
    return x[PSUM_BW-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// Single-column first-word-fall-through FIFO with wrap-bit pointers.
// A write into a full FIFO is accepted only when a pop happens in the same cycle.
module psum_col_fifo
  import psum_pkg::*;
#(
  parameter int W     = PSUM_BW,
  parameter int DEPTH = PSUM_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         wr_drop
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];
  logic         wr_en;
  logic         pop_en;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign pop_en  = pop && !empty;
  assign wr_en   = wr && (!full || pop_en);
  assign wr_drop = wr && full && !pop_en;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en)  wptr <= wptr + 1'b1;
      if (pop_en) rptr <= rptr + 1'b1;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/psum_collector.sv
// Re-aligns skewed south-edge partial sums into full rows, one FIFO per column.
// Optional read-side ReLU is enabled by defining PSUM_COLLECTOR_RELU_EN.
module psum_collector
  import psum_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL,
  parameter int DEPTH   = PSUM_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_ovf
);

  // Read handshake: a row is offered whenever o_valid is high and is consumed at
  // the rising edge where rd && o_valid; rd while !o_valid is ignored. Writes are
  // per column; o_ready low means some column would drop a write unless popped.

  if (bw < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("psum_collector: bw must be positive and DEPTH a power of two >= 2");
  end

  logic [col-1:0]     empty;
  logic [col-1:0]     full;
  logic [col-1:0]     wr_drop;
  logic [psum_bw-1:0] head [col];
  logic               pop;

  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = !o_full;
  assign pop     = rd && o_valid;

  for (genvar c = 0; c < col; c++) begin : g_col
    psum_col_fifo #(
      .W     (psum_bw),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr[c]),
      .din     (in[psum_bw*c +: psum_bw]),
      .pop     (pop),
      .dout    (head[c]),
      .empty   (empty[c]),
      .full    (full[c]),
      .wr_drop (wr_drop[c])
    );

`ifdef PSUM_COLLECTOR_RELU_EN
    assign out[psum_bw*c +: psum_bw] = relu(head[c]);
`else
    assign out[psum_bw*c +: psum_bw] = head[c];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_ovf <= 1'b0;
    else if (|wr_drop) o_ovf <= 1'b1;
  end

endmodule
